mmap_axi_responder: RTL and testbench
=====================================

// Module: mmap_axi_responder
// PURPOSE
//  AXI4 memory responder (slave side) terminating the m_axi_* bus driven by the TAPA async mmap master.
//  Accepts INCR write bursts (AW/W/B) and read bursts (AR/R) into a byte-enabled on-chip memory.
//  Serves as the simulation/emulation memory behind a mmap port and as a synthesizable scratch buffer.
// PARAMETERS
//  AddrWidth          64    byte address width of AWADDR/ARADDR
//  DataWidth          512   beat width in bits
//  DataWidthBytesLog  6     log2(DataWidth/8); must match
//  MemDepthLog        10    memory holds 2**MemDepthLog beats
//  IdWidth            1     AWID/BID/ARID/RID width
// PORTS
//  clk            in   1             clock
//  rst_n          in   1             synchronous active-low reset
//  s_axi_AWVALID  in   1             write addr valid
//  s_axi_AWREADY  out  1             write addr ready
//  s_axi_AWADDR   in   AddrWidth     burst start byte address
//  s_axi_AWID     in   IdWidth       write id, echoed on BID
//  s_axi_AWLEN    in   8             beats-1
//  s_axi_WVALID   in   1             write data valid
//  s_axi_WREADY   out  1             write data ready
//  s_axi_WDATA    in   DataWidth     write beat
//  s_axi_WSTRB    in   DataWidth/8   byte enables
//  s_axi_WLAST    in   1             last beat (informational, see BEHAVIOUR)
//  s_axi_BVALID   out  1             write resp valid
//  s_axi_BREADY   in   1             write resp ready
//  s_axi_BRESP    out  2             write resp code
//  s_axi_BID      out  IdWidth       latched AWID
//  s_axi_ARVALID  in   1             read addr valid
//  s_axi_ARREADY  out  1             read addr ready
//  s_axi_ARADDR   in   AddrWidth     burst start byte address
//  s_axi_ARID     in   IdWidth       read id, echoed on RID
//  s_axi_ARLEN    in   8             beats-1
//  s_axi_RVALID   out  1             read data valid
//  s_axi_RREADY   in   1             read data ready
//  s_axi_RDATA    out  DataWidth     read beat
//  s_axi_RLAST    out  1             high on final beat
//  s_axi_RID      out  IdWidth       latched ARID
//  s_axi_RRESP    out  2             read resp code
// BEHAVIOUR
//  Single clock clk; reset synchronous, active-low (rst_n). All bursts INCR, full-width beats (AxSIZE=DataWidthBytesLog, AxBURST=1).
//  Reset: AWREADY=1, ARREADY=1, WREADY=0, BVALID=0, RVALID=0, RLAST=0, BRESP=RRESP=0, BID=RID=0; memory contents untouched.
//  Word index = ADDR[DataWidthBytesLog +: MemDepthLog]; low DataWidthBytesLog bits ignored; beat k uses index+k mod 2**MemDepthLog.
//  Write FSM W_IDLE->W_DATA->W_RESP->W_IDLE. W_IDLE: AWREADY=1; AW handshake latches index, len, id.
//   W_DATA: WREADY=1; each W handshake writes bytes where WSTRB=1, counter++; beat len -> W_RESP next cycle.
//   Beat counter is authoritative: WLAST is not used for termination.
//   W_RESP: BVALID=1 held until BREADY; then W_IDLE (AWREADY=1 same next cycle). One outstanding write burst.
//  Read FSM R_IDLE->R_DATA->R_IDLE. R_IDLE: ARREADY=1; AR handshake at cycle t -> RVALID=1 at t+1 (registered read).
//   R_DATA: RDATA/RLAST/RID stable while RVALID&&!RREADY; with RREADY held high, beats issue every cycle.
//   RLAST=1 on beat len; its handshake -> R_IDLE, ARREADY=1 next cycle. One outstanding read burst.
//  Read and write FSMs independent; same-cycle write and read of one word: read returns pre-write data.
//  AWLEN/ARLEN=0: single beat, RLAST=1 on first beat. Reset mid-burst: both FSMs to IDLE, partial burst abandoned.
// CONFIGURATION
//  MMAP_RESPONDER_BOUNDS_CHECK_EN defined: if start byte addr >> DataWidthBytesLog, plus len, exceeds 2**MemDepthLog-1,
//   the burst is still fully handshaken but writes are dropped, RDATA=0, BRESP/RRESP=2'b10 (SLVERR) on every beat.
//  Undefined: no check, indices wrap modulo depth, BRESP/RRESP always 2'b00 (OKAY).
// STRUCTURE
//  Package async_mmap_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, wr_state_t {W_IDLE,W_DATA,W_RESP}, rd_state_t {R_IDLE,R_DATA}.
//  Sub-module mmap_responder_mem: 1W1R byte-enabled RAM, registered read port, read-before-write.
// TESTING
//  AW addr=0x40 len=3 id=1, 4 W beats data=i, WSTRB all-1 -> 4 WREADY handshakes, BVALID with BID=1 BRESP=0.
//  AR addr=0x40 len=3 id=1, RREADY=1 -> RVALID at t+1, RDATA 0..3 on 4 consecutive cycles, RLAST on 4th only, RID=1.
//  Write WSTRB=0x...0F over word 0xFF..FF, read back -> only bytes 0-3 updated, rest unchanged.
//  RREADY toggled 1/0 during len=7 read, BREADY held 0 for 5 cycles -> outputs stable while stalled, no beat lost.
//  rst_n=0 for 1 cycle mid-write-burst -> next cycle AWREADY=ARREADY=1, BVALID=RVALID=0; earlier beats persist.
//  With MMAP_RESPONDER_BOUNDS_CHECK_EN, AR to word 2**MemDepthLog-1 len=1 -> 2 beats RDATA=0 RRESP=2'b10.

Source files
------------

// File: rtl/mmap_axi_responder_pkg.sv
// Shared types for the AXI4 memory responder: response codes and FSM states.
package async_mmap_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;

endpackage

// File: rtl/mmap_axi_responder_if.sv
// AXI4 AW/W/B/AR/R channel bundle between a mmap master and the responder.
interface mmap_axi_responder_if #(
  parameter int AddrWidth = 64,
  parameter int DataWidth = 512,
  parameter int IdWidth   = 1
);
  logic                   AWVALID, AWREADY;
  logic [AddrWidth-1:0]   AWADDR;
  logic [IdWidth-1:0]     AWID;
  logic [7:0]             AWLEN;
  logic                   WVALID, WREADY;
  logic [DataWidth-1:0]   WDATA;
  logic [DataWidth/8-1:0] WSTRB;
  logic                   WLAST;
  logic                   BVALID, BREADY;
  logic [1:0]             BRESP;
  logic [IdWidth-1:0]     BID;
  logic                   ARVALID, ARREADY;
  logic [AddrWidth-1:0]   ARADDR;
  logic [IdWidth-1:0]     ARID;
  logic [7:0]             ARLEN;
  logic                   RVALID, RREADY;
  logic [DataWidth-1:0]   RDATA;
  logic                   RLAST;
  logic [IdWidth-1:0]     RID;
  logic [1:0]             RRESP;

  modport slave (
    input  AWVALID, AWADDR, AWID, AWLEN, WVALID, WDATA, WSTRB, WLAST, BREADY,
           ARVALID, ARADDR, ARID, ARLEN, RREADY,
    output AWREADY, WREADY, BVALID, BRESP, BID, ARREADY, RVALID, RDATA, RLAST, RID, RRESP
  );

  modport master (
    output AWVALID, AWADDR, AWID, AWLEN, WVALID, WDATA, WSTRB, WLAST, BREADY,
           ARVALID, ARADDR, ARID, ARLEN, RREADY,
    input  AWREADY, WREADY, BVALID, BRESP, BID, ARREADY, RVALID, RDATA, RLAST, RID, RRESP
  );
endinterface

// File: rtl/mmap_axi_responder_mem.sv
// 1W1R byte-enabled RAM with a registered, enable-gated read port.
// Read-before-write: a same-cycle read of the written word returns old data.
module mmap_responder_mem #(
  parameter int DataWidth = 512,
  parameter int DepthLog  = 10
) (
  input  logic                   i_clk,
  input  logic                   i_we,
  input  logic [DepthLog-1:0]    i_waddr,
  input  logic [DataWidth-1:0]   i_wdata,
  input  logic [DataWidth/8-1:0] i_wstrb,
  input  logic                   i_re,
  input  logic [DepthLog-1:0]    i_raddr,
  output logic [DataWidth-1:0]   o_rdata
);
  logic [DataWidth-1:0] r_mem [2**DepthLog];
  logic [DataWidth-1:0] r_rdata;

  // Byte-lane write; array has no reset so contents survive rst_n.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < DataWidth/8; b++)
      if (i_we && i_wstrb[b]) r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
  end

  // Read register only loads when enabled, so it holds through stalls.
  always_ff @(posedge i_clk) begin
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/mmap_axi_responder.sv
// AXI4 INCR-burst memory responder. Independent write (AW/W/B) and read (AR/R)
// FSMs, one outstanding burst each. Optional feature: define
// MMAP_RESPONDER_BOUNDS_CHECK_EN to flag bursts running past the last word
// (writes dropped, RDATA=0, SLVERR); otherwise indices wrap modulo depth.
module mmap_axi_responder
  import async_mmap_pkg::*;
#(
  parameter int AddrWidth         = 64,
  parameter int DataWidth         = 512,
  parameter int DataWidthBytesLog = 6,
  parameter int MemDepthLog       = 10,
  parameter int IdWidth           = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  mmap_axi_responder_if.slave s_axi
);
  typedef logic [MemDepthLog-1:0] idx_t;

  wr_state_t          r_wstate, w_wstate_nxt;
  idx_t               r_wptr;
  logic [7:0]         r_wlen, r_wcnt;
  logic [IdWidth-1:0] r_bid;
  logic               r_werr;

  rd_state_t          r_rstate, w_rstate_nxt;
  idx_t               r_rptr;
  logic [7:0]         r_rlen, r_rcnt;
  logic [IdWidth-1:0] r_rid;
  logic               r_rerr;

  logic w_awhs, w_whs, w_arhs, w_radv, w_aw_oob, w_ar_oob;
  logic w_mem_re;
  idx_t w_mem_raddr;
  logic [DataWidth-1:0] w_mem_rdata;
  logic w_unused_bits;

  assign w_awhs = (r_wstate == W_IDLE) && s_axi.AWVALID;
  assign w_whs  = (r_wstate == W_DATA) && s_axi.WVALID;
  assign w_arhs = (r_rstate == R_IDLE) && s_axi.ARVALID;
  // Advance to the next read beat when the current one is taken and is not the last.
  assign w_radv = (r_rstate == R_DATA) && s_axi.RREADY && (r_rcnt != r_rlen);

`ifdef MMAP_RESPONDER_BOUNDS_CHECK_EN
  // Burst is out of range when start word index plus len passes the last word.
  function automatic logic f_oob(input logic [AddrWidth-1:0] a, input logic [7:0] len);
    logic [AddrWidth:0] w_end;
    w_end = {1'b0, a >> DataWidthBytesLog} + {{(AddrWidth-7){1'b0}}, len};
    return w_end > (AddrWidth+1)'((64'd1 << MemDepthLog) - 64'd1);
  endfunction
  assign w_aw_oob      = f_oob(s_axi.AWADDR, s_axi.AWLEN);
  assign w_ar_oob      = f_oob(s_axi.ARADDR, s_axi.ARLEN);
  assign w_unused_bits = s_axi.WLAST;
`else
  assign w_aw_oob      = 1'b0;
  assign w_ar_oob      = 1'b0;
  assign w_unused_bits = ^{s_axi.WLAST, s_axi.AWADDR, s_axi.ARADDR};
`endif

  // Write state and burst context; beat counter alone ends the burst (WLAST ignored).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wstate <= W_IDLE;
      r_wptr   <= '0;
      r_wlen   <= '0;
      r_wcnt   <= '0;
      r_bid    <= '0;
      r_werr   <= 1'b0;
    end else begin
      r_wstate <= w_wstate_nxt;
      if (w_awhs) begin
        r_wptr <= s_axi.AWADDR[DataWidthBytesLog +: MemDepthLog];
        r_wlen <= s_axi.AWLEN;
        r_wcnt <= '0;
        r_bid  <= s_axi.AWID;
        r_werr <= w_aw_oob;
      end else if (w_whs) begin
        r_wptr <= r_wptr + idx_t'(1);
        r_wcnt <= r_wcnt + 8'd1;
      end
    end
  end

  // Write next-state and channel outputs.
  always_comb begin
    w_wstate_nxt  = r_wstate;
    s_axi.AWREADY = 1'b0;
    s_axi.WREADY  = 1'b0;
    s_axi.BVALID  = 1'b0;
    s_axi.BRESP   = r_werr ? RESP_SLVERR : RESP_OKAY;
    s_axi.BID     = r_bid;
    case (r_wstate)
      W_IDLE: begin
        s_axi.AWREADY = 1'b1;
        if (s_axi.AWVALID) w_wstate_nxt = W_DATA;
      end
      W_DATA: begin
        s_axi.WREADY = 1'b1;
        if (s_axi.WVALID && (r_wcnt == r_wlen)) w_wstate_nxt = W_RESP;
      end
      W_RESP: begin
        s_axi.BVALID = 1'b1;
        if (s_axi.BREADY) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Read state and burst context; r_rptr tracks the word currently on RDATA.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rstate <= R_IDLE;
      r_rptr   <= '0;
      r_rlen   <= '0;
      r_rcnt   <= '0;
      r_rid    <= '0;
      r_rerr   <= 1'b0;
    end else begin
      r_rstate <= w_rstate_nxt;
      if (w_arhs) begin
        r_rptr <= s_axi.ARADDR[DataWidthBytesLog +: MemDepthLog];
        r_rlen <= s_axi.ARLEN;
        r_rcnt <= '0;
        r_rid  <= s_axi.ARID;
        r_rerr <= w_ar_oob;
      end else if (w_radv) begin
        r_rptr <= r_rptr + idx_t'(1);
        r_rcnt <= r_rcnt + 8'd1;
      end
    end
  end

  // Read next-state and channel outputs.
  always_comb begin
    w_rstate_nxt  = r_rstate;
    s_axi.ARREADY = 1'b0;
    s_axi.RVALID  = 1'b0;
    s_axi.RLAST   = 1'b0;
    s_axi.RID     = r_rid;
    s_axi.RRESP   = r_rerr ? RESP_SLVERR : RESP_OKAY;
    s_axi.RDATA   = r_rerr ? '0 : w_mem_rdata;
    case (r_rstate)
      R_IDLE: begin
        s_axi.ARREADY = 1'b1;
        if (s_axi.ARVALID) w_rstate_nxt = R_DATA;
      end
      R_DATA: begin
        s_axi.RVALID = 1'b1;
        s_axi.RLAST  = (r_rcnt == r_rlen);
        if (s_axi.RREADY && (r_rcnt == r_rlen)) w_rstate_nxt = R_IDLE;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Fetch the first beat on AR handshake, the following beat on each accepted non-last beat.
  assign w_mem_re    = w_arhs || w_radv;
  assign w_mem_raddr = w_arhs ? s_axi.ARADDR[DataWidthBytesLog +: MemDepthLog] : r_rptr + idx_t'(1);

  mmap_responder_mem #(
    .DataWidth (DataWidth),
    .DepthLog  (MemDepthLog)
  ) u_mem (
    .i_clk   (clk),
    .i_we    (w_whs && !r_werr),
    .i_waddr (r_wptr),
    .i_wdata (s_axi.WDATA),
    .i_wstrb (s_axi.WSTRB),
    .i_re    (w_mem_re),
    .i_raddr (w_mem_raddr),
    .o_rdata (w_mem_rdata)
  );
endmodule

// File: tb/tb_mmap_axi_responder.sv
// Directed bench for mmap_axi_responder: single-beat vector table plus burst,
// stall, reset and wrap/bounds sequences. Inputs driven and outputs sampled on negedge.
module tb_mmap_axi_responder;
  import async_mmap_pkg::*;

  localparam int AW = 64, DW = 64, BL = 3, MD = 6, IW = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mmap_axi_responder_if #(.AddrWidth(AW), .DataWidth(DW), .IdWidth(IW)) bus ();

  mmap_axi_responder #(
    .AddrWidth(AW), .DataWidth(DW), .DataWidthBytesLog(BL), .MemDepthLog(MD), .IdWidth(IW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s_axi (bus.slave)
  );

  typedef struct {
    bit          wr;
    logic [63:0] addr;
    logic [7:0]  strb;
    logic [63:0] data;  // write data, or expected read data
    logic [1:0]  resp;
  } vec_t;

  vec_t        tbl[$];
  logic [63:0] exp_d [0:15];
  int          n_pass = 0;
  int          n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic bus_idle();
    bus.AWVALID = 0; bus.AWADDR = '0; bus.AWID = '0; bus.AWLEN = '0;
    bus.WVALID = 0; bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 0; bus.BREADY = 0;
    bus.ARVALID = 0; bus.ARADDR = '0; bus.ARID = '0; bus.ARLEN = '0; bus.RREADY = 0;
  endtask

  task automatic do_write(input logic [63:0] addr, input logic [7:0] len, input logic [IW-1:0] id,
                          input logic [63:0] dbase, input logic [7:0] strb, input int bdly,
                          input logic [1:0] eresp);
    int k;
    @(negedge clk);
    chk("awready", bus.AWREADY, 1);
    bus.AWVALID = 1; bus.AWADDR = addr; bus.AWID = id; bus.AWLEN = len;
    @(negedge clk);
    bus.AWVALID = 0;
    for (int i = 0; i <= int'(len); i++) begin
      chk("wready", bus.WREADY, 1);
      bus.WVALID = 1; bus.WDATA = dbase + 64'(i); bus.WSTRB = strb; bus.WLAST = (i == int'(len));
      @(negedge clk);
    end
    bus.WVALID = 0; bus.WLAST = 0;
    k = 0;
    while (!bus.BVALID && k < 8) begin @(negedge clk); k++; end
    chk("bvalid", bus.BVALID, 1);
    chk("bid", bus.BID, id);
    chk("bresp", bus.BRESP, eresp);
    for (int i = 0; i < bdly; i++) begin
      @(negedge clk);
      chk("bvalid_hold", bus.BVALID, 1);
      chk("bid_hold", bus.BID, id);
    end
    bus.BREADY = 1;
    @(negedge clk);
    bus.BREADY = 0;
    chk("bvalid_clr", bus.BVALID, 0);
    chk("awready_after_b", bus.AWREADY, 1);
  endtask

  // Expected beats come from exp_d. With stall set, even beats are held off two cycles.
  task automatic do_read(input logic [63:0] addr, input logic [7:0] len, input logic [IW-1:0] id,
                         input bit stall, input logic [1:0] eresp);
    @(negedge clk);
    chk("arready", bus.ARREADY, 1);
    bus.ARVALID = 1; bus.ARADDR = addr; bus.ARID = id; bus.ARLEN = len;
    @(negedge clk);
    bus.ARVALID = 0;
    chk("rvalid_t1", bus.RVALID, 1);
    for (int b = 0; b <= int'(len); b++) begin
      if (stall && (b % 2 == 0)) begin
        bus.RREADY = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rvalid_stall", bus.RVALID, 1);
        chk("rdata_stall", bus.RDATA, exp_d[b]);
        chk("rlast_stall", bus.RLAST, (b == int'(len)) ? 64'd1 : 64'd0);
      end
      bus.RREADY = 1;
      chk("rvalid", bus.RVALID, 1);
      chk("rdata", bus.RDATA, exp_d[b]);
      chk("rlast", bus.RLAST, (b == int'(len)) ? 64'd1 : 64'd0);
      chk("rid", bus.RID, id);
      chk("rresp", bus.RRESP, eresp);
      @(negedge clk);
    end
    bus.RREADY = 0;
    chk("rvalid_clr", bus.RVALID, 0);
    chk("arready_after_r", bus.ARREADY, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    tbl.push_back('{1'b1, 64'h100, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, RESP_OKAY});
    tbl.push_back('{1'b1, 64'h100, 8'h0F, 64'h1122_3344_5566_7788, RESP_OKAY});
    tbl.push_back('{1'b0, 64'h100, 8'h00, 64'hFFFF_FFFF_5566_7788, RESP_OKAY});
    tbl.push_back('{1'b1, 64'h107, 8'hF0, 64'hAABB_CCDD_0000_0000, RESP_OKAY});
    tbl.push_back('{1'b0, 64'h105, 8'h00, 64'hAABB_CCDD_5566_7788, RESP_OKAY});
    tbl.push_back('{1'b1, 64'h108, 8'hFF, 64'h0,                   RESP_OKAY});
    tbl.push_back('{1'b1, 64'h108, 8'h81, 64'h0102_0304_0506_0708, RESP_OKAY});
    tbl.push_back('{1'b0, 64'h108, 8'h00, 64'h0100_0000_0000_0008, RESP_OKAY});
`ifndef MMAP_RESPONDER_BOUNDS_CHECK_EN
    tbl.push_back('{1'b1, 64'h208, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, RESP_OKAY});
    tbl.push_back('{1'b0, 64'h008, 8'h00, 64'hDEAD_BEEF_CAFE_F00D, RESP_OKAY});
    tbl.push_back('{1'b0, 64'h40F, 8'h00, 64'hDEAD_BEEF_CAFE_F00D, RESP_OKAY});
`endif

    bus_idle();
    rst_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_awready", bus.AWREADY, 1);
    chk("rst_arready", bus.ARREADY, 1);
    chk("rst_wready", bus.WREADY, 0);
    chk("rst_bvalid", bus.BVALID, 0);
    chk("rst_rvalid", bus.RVALID, 0);
    chk("rst_rlast", bus.RLAST, 0);
    chk("rst_bresp", bus.BRESP, 0);
    chk("rst_rresp", bus.RRESP, 0);
    chk("rst_bid", bus.BID, 0);
    chk("rst_rid", bus.RID, 0);
    rst_n = 1;

    foreach (tbl[i]) begin
      if (tbl[i].wr) begin
        do_write(tbl[i].addr, 8'd0, '0, tbl[i].data, tbl[i].strb, 0, tbl[i].resp);
      end else begin
        exp_d[0] = tbl[i].data;
        do_read(tbl[i].addr, 8'd0, '0, 1'b0, tbl[i].resp);
      end
    end

    // 4-beat burst write then back-to-back read at 0x40 with id 1.
    do_write(64'h40, 8'd3, 1'b1, 64'd0, 8'hFF, 0, RESP_OKAY);
    for (int i = 0; i < 4; i++) exp_d[i] = 64'(i);
    do_read(64'h40, 8'd3, 1'b1, 1'b0, RESP_OKAY);

    // len=7 burst with BREADY held off 5 cycles, read back with RREADY stalls.
    do_write(64'h80, 8'd7, 1'b0, 64'h100, 8'hFF, 5, RESP_OKAY);
    for (int i = 0; i < 8; i++) exp_d[i] = 64'h100 + 64'(i);
    do_read(64'h80, 8'd7, 1'b0, 1'b1, RESP_OKAY);

    // Reset after two of four write beats; those two beats must persist.
    @(negedge clk);
    bus.AWVALID = 1; bus.AWADDR = 64'hC0; bus.AWID = 1'b1; bus.AWLEN = 8'd3;
    @(negedge clk);
    bus.AWVALID = 0;
    for (int i = 0; i < 2; i++) begin
      bus.WVALID = 1; bus.WDATA = 64'h500 + 64'(i); bus.WSTRB = 8'hFF;
      @(negedge clk);
    end
    bus.WVALID = 0;
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("mid_rst_awready", bus.AWREADY, 1);
    chk("mid_rst_arready", bus.ARREADY, 1);
    chk("mid_rst_bvalid", bus.BVALID, 0);
    chk("mid_rst_rvalid", bus.RVALID, 0);
    chk("mid_rst_wready", bus.WREADY, 0);
    exp_d[0] = 64'h500; exp_d[1] = 64'h501;
    do_read(64'hC0, 8'd1, 1'b0, 1'b0, RESP_OKAY);

`ifdef MMAP_RESPONDER_BOUNDS_CHECK_EN
    // Burst from the last word with len=1 runs past the end.
    do_write(64'h1F8, 8'd1, 1'b1, 64'h700, 8'hFF, 0, RESP_SLVERR);
    exp_d[0] = 64'd0; exp_d[1] = 64'd0;
    do_read(64'h1F8, 8'd1, 1'b1, 1'b0, RESP_SLVERR);
`else
    // Burst from the last word wraps to word 0.
    do_write(64'h1F8, 8'd1, 1'b1, 64'h700, 8'hFF, 0, RESP_OKAY);
    exp_d[0] = 64'h700; exp_d[1] = 64'h701;
    do_read(64'h1F8, 8'd1, 1'b1, 1'b0, RESP_OKAY);
    exp_d[0] = 64'h701;
    do_read(64'h000, 8'd0, 1'b0, 1'b0, RESP_OKAY);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
